// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over back-to-back
// gate windows of GATE_CYCLES clk cycles and reports each completed count.
//
// state   | meaning
// IDLE    | counters cleared, freq_out/overflow held, waiting for en
// MEASURE | gate window running; its last cycle reports and restarts the window
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 25000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq_out,
  output logic             overflow,
  output logic             valid
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             sync1;
  logic             sync2;
  logic             sig_prev;
  logic             edge_det;
  logic [31:0]      gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             gate_last;
  logic             win_run;
  logic             win_close;
  logic             edge_at_max;
  logic [CNT_W-1:0] cnt_final;

  // Synchroniser and edge detector run even in IDLE so enabling while sig_in
  // is already high cannot be mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sync1    <= sig_in;
      sync2    <= sync1;
      sig_prev <= sync2;
    end
  end

  assign edge_det = sync2 & ~sig_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = MEASURE;
      MEASURE: if (!en) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  assign gate_last = (gate_cnt == GATE_LAST);

  // The close cycle ignores en so a window whose last cycle sees en fall still reports.
  always_comb begin
    win_run   = 1'b0;
    win_close = 1'b0;
    case (state)
      MEASURE: begin
        win_close = gate_last;
        win_run   = en & ~gate_last;
      end
      default: begin
        win_run   = 1'b0;
        win_close = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
    end else if (win_run) begin
      gate_cnt <= gate_cnt + 32'd1;
    end else begin
      gate_cnt <= '0;
    end
  end

  assign edge_at_max = edge_det & (edge_cnt == CNT_MAX);
  assign cnt_final   = (edge_det && !edge_at_max) ? edge_cnt + CNT_ONE : edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (win_run) begin
      edge_cnt <= cnt_final;
      if (edge_at_max) begin
        sat <= 1'b1;
      end
    end else begin
      edge_cnt <= '0;
      sat      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= win_close;
      if (win_close) begin
        freq_out <= cnt_final;
        overflow <= sat | edge_at_max;
      end
    end
  end

endmodule
